// File: rtl/burst_rom_pkg.sv
// Shared types and ROM content for burst_rom: FSM state encoding and the
// Gray-code table function. Optional feature macro: BURST_ROM_PARITY_EN.
package burst_rom_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Gray code of the address; callers truncate to their data width.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return addr ^ (addr >> 1);
  endfunction

endpackage

// File: rtl/burst_rom_rom_array.sv
// Purely combinational constant-table lookup for burst_rom (addr -> data).
// Optional feature macro of the enclosing design: BURST_ROM_PARITY_EN (unused here).
module rom_array
  import burst_rom_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = DATA_W'(rom_word(32'(addr)));
  end

endmodule

// File: rtl/burst_rom.sv
// Gray-code ROM with a burst-read engine and a registered valid/ready output.
// Define BURST_ROM_PARITY_EN to add the registered rsp_par output.
module burst_rom
  import burst_rom_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last
`ifdef BURST_ROM_PARITY_EN
  ,
  output logic              rsp_par
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]   rom_data;
  logic                adv;
`ifdef BURST_ROM_PARITY_EN
  logic                rsp_par_q, rsp_par_d;
`endif

  rom_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .addr(cur_addr_q),
    .data(rom_data)
  );

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
`ifdef BURST_ROM_PARITY_EN
    rsp_par_d   = rsp_par_q;
`endif
    req_ready   = (state_q == IDLE);
    // Output register is free when empty or its current beat is being taken.
    adv         = en && (state_q == BURST) && (!rsp_valid_q || rsp_ready);

    if (en && req_valid && (state_q == IDLE)) begin
      cur_addr_d = req_addr;
      cnt_d      = req_len;
      state_d    = BURST;
    end

    if (adv) begin
      rsp_data_d  = rom_data;
      rsp_valid_d = 1'b1;
      rsp_last_d  = (cnt_q == '0);
`ifdef BURST_ROM_PARITY_EN
      rsp_par_d   = ^rom_data;
`endif
      cur_addr_d  = (cur_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;
      cnt_d       = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = IDLE;
      end
    end else if (en && rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef BURST_ROM_PARITY_EN
      rsp_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
`ifdef BURST_ROM_PARITY_EN
      rsp_par_q   <= rsp_par_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
`ifdef BURST_ROM_PARITY_EN
  assign rsp_par   = rsp_par_q;
`endif

endmodule

// File: tb/tb_burst_rom.sv
// Directed self-checking bench for burst_rom (default 4/4/3 configuration).
// Parity checks are built only when BURST_ROM_PARITY_EN is defined.
module tb_burst_rom;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_addr = '0;
  logic [2:0] req_len = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic       rsp_last;
`ifdef BURST_ROM_PARITY_EN
  logic       rsp_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  burst_rom #(
    .DATA_W(4),
    .ADDR_W(4),
    .LEN_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last)
`ifdef BURST_ROM_PARITY_EN
    ,
    .rsp_par  (rsp_par)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic issue_req(input logic [3:0] addr, input logic [2:0] len);
    int unsigned waited = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    while (!req_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: req_ready=%b required 1 within 20 cycles", req_ready);
    end
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_last, rsp_data, req_ready} !== 7'b00_0000_1) begin
      n_fail++;
      $display("FAIL reset_state: v/l/d/rr=%b/%b/%h/%b required 0/0/0/1",
               rsp_valid, rsp_last, rsp_data, req_ready);
    end
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_beat();
    rsp_ready = 1'b1;
    issue_req(4'hA, 3'd0);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_accept: rr/v=%b/%b required 0/0", req_ready, rsp_valid);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_last, rsp_data, req_ready} !== {1'b1, 1'b1, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL single_beat: v/l/d/rr=%b/%b/%h/%b required 1/1/f/1",
               rsp_valid, rsp_last, rsp_data, req_ready);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_d [3] = '{4'h5, 4'h4, 4'hC};
    rsp_ready = 1'b1;
    issue_req(4'h6, 3'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, (i == 2), exp_d[i]}) begin
        n_fail++;
        $display("FAIL burst_beat%0d: v/l/d=%b/%b/%h required 1/%b/%h",
                 i, rsp_valid, rsp_last, rsp_data, (i == 2), exp_d[i]);
      end
    end
    step();
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_end: v/rr=%b/%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_d [4] = '{4'h9, 4'h8, 4'h0, 4'h1};
    rsp_ready = 1'b1;
    issue_req(4'hE, 3'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, (i == 3), exp_d[i]}) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: v/l/d=%b/%b/%h required 1/%b/%h",
                 i, rsp_valid, rsp_last, rsp_data, (i == 3), exp_d[i]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue_req(4'h3, 3'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_last, rsp_data, req_ready} !== {1'b1, 1'b0, 4'h2, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v/l/d/rr=%b/%b/%h/%b required 1/0/2/0",
                 i, rsp_valid, rsp_last, rsp_data, req_ready);
      end
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, 1'b1, 4'h6}) begin
      n_fail++;
      $display("FAIL bp_second: v/l/d=%b/%b/%h required 1/1/6", rsp_valid, rsp_last, rsp_data);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_d [3] = '{4'h1, 4'h3, 4'h2};
    rsp_ready = 1'b1;
    issue_req(4'h0, 3'd3);
    step();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, 1'b0, 4'h0}) begin
        n_fail++;
        $display("FAIL en_frozen%0d: v/l/d=%b/%b/%h required 1/0/0",
                 i, rsp_valid, rsp_last, rsp_data);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, (i == 2), exp_d[i]}) begin
        n_fail++;
        $display("FAIL en_resume%0d: v/l/d=%b/%b/%h required 1/%b/%h",
                 i, rsp_valid, rsp_last, rsp_data, (i == 2), exp_d[i]);
      end
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drain: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b1;
    issue_req(4'h0, 3'd3);
    step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_data, req_ready} !== 6'b0_0000_1) begin
      n_fail++;
      $display("FAIL async_reset: v/d/rr=%b/%h/%b required 0/0/1", rsp_valid, rsp_data, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_reset: v/rr=%b/%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    issue_req(4'h1, 3'd1);
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_last, rsp_data, req_ready} !== {1'b1, 1'b1, 4'h3, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_last: v/l/d/rr=%b/%b/%h/%b required 1/1/3/1",
               rsp_valid, rsp_last, rsp_data, req_ready);
    end
    issue_req(4'h5, 3'd0);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_bubble: rsp_valid=%b required 0", rsp_valid);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, 1'b1, 4'h7}) begin
      n_fail++;
      $display("FAIL b2b_second: v/l/d=%b/%b/%h required 1/1/7", rsp_valid, rsp_last, rsp_data);
    end
    step();
    // New request accepted while the final beat is still held by backpressure.
    rsp_ready = 1'b0;
    issue_req(4'h2, 3'd0);
    step();
    issue_req(4'h4, 3'd0);
    n_checks++;
    if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 4'h3, 1'b0}) begin
      n_fail++;
      $display("FAIL overlap_hold: v/d/rr=%b/%h/%b required 1/3/0", rsp_valid, rsp_data, req_ready);
    end
    step();
    n_checks++;
    if (rsp_data !== 4'h3) begin
      n_fail++;
      $display("FAIL overlap_stall: rsp_data=%h required 3", rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, 1'b1, 4'h6}) begin
      n_fail++;
      $display("FAIL overlap_next: v/l/d=%b/%b/%h required 1/1/6", rsp_valid, rsp_last, rsp_data);
    end
    step();
  endtask

`ifdef BURST_ROM_PARITY_EN
  task automatic test_parity();
    rsp_ready = 1'b1;
    issue_req(4'hF, 3'd0);
    step();
    n_checks++;
    if ({rsp_data, rsp_par} !== {4'h8, 1'b1}) begin
      n_fail++;
      $display("FAIL parity_f: d/par=%h/%b required 8/1", rsp_data, rsp_par);
    end
    step();
    issue_req(4'h6, 3'd0);
    step();
    n_checks++;
    if ({rsp_data, rsp_par} !== {4'h5, 1'b0}) begin
      n_fail++;
      $display("FAIL parity_6: d/par=%h/%b required 5/0", rsp_data, rsp_par);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_burst();
    test_wrap();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_back_to_back();
`ifdef BURST_ROM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
